// File: rtl/mips_multicycle_sequencer.sv
// Multicycle control sequencer for the MIPS datapath: accepts one instruction, walks it through DECODE/EXEC/MEM/WB.
// Optional build macro SEQ_PERF_CNT_EN adds the busy_cycles performance counter output.
module mips_multicycle_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr_word,
  output logic             instr_ready,
  output logic [31:0]      ir,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      busy_cycles
`endif
);

  localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CL_BAD = 2'd0,
    CL_R   = 2'd1,
    CL_LW  = 2'd2,
    CL_SW  = 2'd3
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] funct);
    iclass_t c;
    c = CL_BAD;
    if (op == 6'd0) begin
      if (funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42}) c = CL_R;
    end else if (op == 6'd35) begin
      c = CL_LW;
    end else if (op == 6'd43) begin
      c = CL_SW;
    end
    return c;
  endfunction

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic                accept;
  iclass_t             ir_class, ir_class_d;
  logic                reg_write_d, mem_read_d, mem_write_d, done_d, illegal_d, busy_d;

  assign ir_class    = classify(ir[31:26], ir[5:0]);
  assign accept      = (state == IDLE) && instr_valid;
  assign ir_class_d  = accept ? classify(instr_word[31:26], instr_word[5:0]) : ir_class;
  assign instr_ready = rst && (state == IDLE);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    wait_cnt_d = wait_cnt;
    case (state)
      IDLE:   if (instr_valid) next_state = DECODE;
      DECODE: next_state = (ir_class == CL_BAD) ? IDLE : EXEC;
      EXEC: begin
        if (ir_class == CL_R) begin
          next_state = WB;
        end else begin
          next_state = MEM;
          wait_cnt_d = WAIT_W'(MEM_WAIT);
        end
      end
      MEM: begin
        if (wait_cnt == '0) next_state = (ir_class == CL_LW) ? WB : IDLE;
        else                wait_cnt_d = wait_cnt - WAIT_W'(1);
      end
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each is a clean flop output.
  always_comb begin
    reg_write_d = (next_state == WB);
    mem_read_d  = (next_state == MEM) && (ir_class_d == CL_LW);
    mem_write_d = (next_state == MEM) && (ir_class_d == CL_SW);
    done_d      = (next_state == WB) ||
                  ((next_state == MEM) && (ir_class_d == CL_SW) && (wait_cnt_d == '0));
    illegal_d   = (next_state == DECODE) && (ir_class_d == CL_BAD);
    busy_d      = (next_state != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ir            <= '0;
      wait_cnt      <= '0;
      retired_count <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_d;
      reg_write <= reg_write_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      done      <= done_d;
      illegal   <= illegal_d;
      busy      <= busy_d;
      if (accept) ir <= instr_word;
      if (done)   retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Static datapath controls follow the latched instruction while it is in flight.
  always_comb begin
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    if (state != IDLE) begin
      case (ir_class)
        CL_R: begin
          mem_to_reg = 1'b1;
          reg_dst    = 1'b1;
          alu_op     = 2'b10;
        end
        CL_LW: alu_src = 1'b1;
        CL_SW: begin
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           busy_cycles <= '0;
    else if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench: directed plan cases plus randomized instructions against a per-instruction trace model.
module tb_mips_multicycle_sequencer;

  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [31:0]      instr_word;
  logic             instr_ready;
  logic [31:0]      ir;
  logic             reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
  logic [1:0]       alu_op;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] retired_count;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]      busy_cycles;
`endif

  mips_multicycle_sequencer #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_word    (instr_word),
    .instr_ready   (instr_ready),
    .ir            (ir),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .retired_count (retired_count)
`ifdef SEQ_PERF_CNT_EN
    ,
    .busy_cycles   (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       done;
    logic       illegal;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } obs_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   model_count = 0;
  int   model_busy  = 0;
  obs_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy;           o.reg_write = reg_write; o.mem_read = mem_read;
    o.mem_write = mem_write; o.done = done;           o.illegal = illegal;
    o.mem_to_reg = mem_to_reg; o.reg_dst = reg_dst;   o.alu_src = alu_src;
    o.alu_op = alu_op;
    return o;
  endfunction

  // Expected per-cycle outputs from the accept edge to the retiring cycle, straight from the phase rules.
  function automatic void build_trace(input logic [31:0] w);
    obs_t base, e;
    logic [5:0] op, fn;
    bit is_r, is_lw, is_sw;
    op = w[31:26];
    fn = w[5:0];
    is_r  = (op == 6'd0) && (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42);
    is_lw = (op == 6'd35);
    is_sw = (op == 6'd43);
    exp_q.delete();
    base = '0;
    base.busy = 1'b1;
    if (!(is_r || is_lw || is_sw)) begin
      e = base; e.illegal = 1'b1;
      exp_q.push_back(e);
      return;
    end
    if (is_r)  begin base.mem_to_reg = 1; base.reg_dst = 1; base.alu_op = 2'b10; end
    if (is_lw) begin base.alu_src = 1; end
    if (is_sw) begin base.mem_to_reg = 1; base.alu_src = 1; end
    exp_q.push_back(base);
    exp_q.push_back(base);
    if (is_lw || is_sw) begin
      for (int i = 0; i <= MEM_WAIT; i++) begin
        e = base;
        e.mem_read  = is_lw;
        e.mem_write = is_sw;
        e.done      = is_sw && (i == MEM_WAIT);
        exp_q.push_back(e);
      end
    end
    if (is_r || is_lw) begin
      e = base; e.reg_write = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Called at a negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after retirement.
  task automatic run_instr(input logic [31:0] w, input bit noise);
    bit retires;
    build_trace(w);
    retires = exp_q[exp_q.size()-1].done;
    check("ready_before_accept", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr_word  = w;
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      instr_valid = noise ? 1'($urandom) : 1'b0;
      instr_word  = $urandom;
      @(negedge clk);
      check($sformatf("obs_%08h_c%0d", w, i), 32'(observe()), 32'(exp_q[i]));
      check($sformatf("ready_busy_%08h_c%0d", w, i), instr_ready, 1'b0);
      check($sformatf("ir_%08h_c%0d", w, i), ir, w);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    model_busy += exp_q.size();
    if (retires) model_count = (model_count + 1) % (1 << CNT_W);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", instr_ready, 1'b1);
    check("retired_count", 32'(retired_count), model_count);
`ifdef SEQ_PERF_CNT_EN
    check("busy_cycles", busy_cycles, model_busy);
`endif
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      instr_word  = $urandom;
      @(negedge clk);
      check("gap_busy", busy, 1'b0);
      check("gap_ready", instr_ready, 1'b1);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin
        w[31:26] = 6'd0;
        case ($urandom_range(0, 4))
          0: w[5:0] = 6'd32;
          1: w[5:0] = 6'd34;
          2: w[5:0] = 6'd36;
          3: w[5:0] = 6'd37;
          default: w[5:0] = 6'd42;
        endcase
      end
      1: w[31:26] = 6'd35;
      2: w[31:26] = 6'd43;
      3: w[31:26] = 6'd0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    instr_valid = 1'b0;
    instr_word  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1'b0);
    check("rst_obs", 32'(observe()), 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_count", 32'(retired_count), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    run_instr(32'h00221820, 1'b0);
    run_instr(32'h8C220004, 1'b0);
    run_instr(32'hAC220008, 1'b0);
    run_instr(32'hFC000000, 1'b0);
    run_instr(32'h00000003, 1'b0);

    // Reset during the first MEM cycle of a lw must abort it immediately.
    instr_valid = 1'b1;
    instr_word  = 32'h8C220004;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_mem_read", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_read", mem_read, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ir", ir, 32'h0);
    check("abort_ready", instr_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_count = 0;
    model_busy  = 0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_count", 32'(retired_count), 32'h0);
`ifdef SEQ_PERF_CNT_EN
    check("post_rst_busy_cycles", busy_cycles, 32'h0);
`endif

    // Back-to-back R-types walk the narrow counter through its wrap.
    for (int i = 0; i < 10; i++) run_instr(32'h00221820, 1'b1);

    for (int i = 0; i < 60; i++) begin
      idle_gap($urandom_range(0, 2));
      run_instr(rand_instr(), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multicycle control sequencer for the MIPS datapath (register file, ALU, data memory, muxes). Replaces the free-running control FSM.
- Accepts one instruction word at a time via a valid/ready handshake and latches it into an instruction register.
- Issues register/memory strobes and static mux controls per phase, and reports retirement and illegal instructions.
- Supports R-type (add, sub, and, or, slt), lw (opcode 35) and sw (opcode 43).

Parameters:
- MEM_WAIT, default 0: extra data-memory wait cycles; MEM phase lasts MEM_WAIT+1 cycles.
- CNT_W, default 16: width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instr_word holds a new instruction.
- instr_word  in  32  instruction to execute.
- instr_ready  out  1  sequencer can accept an instruction.
- ir  out  32  latched instruction register; drives datapath fields.
- reg_write  out  1  register-file write strobe.
- mem_read  out  1  data-memory read strobe.
- mem_write  out  1  data-memory write strobe.
- mem_to_reg  out  1  writeback mux select (1 = ALU result, 0 = memory data).
- reg_dst  out  1  destination select (1 = ir[15:11], 0 = ir[20:16]).
- alu_src  out  1  ALU operand-B select (1 = sign-extended immediate).
- alu_op  out  2  ALU control class (2'b10 = R-type, 2'b00 = add).
- busy  out  1  instruction in flight (state != IDLE).
- done  out  1  one-cycle pulse in the retiring cycle.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- retired_count  out  CNT_W  retired legal instructions; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ir=0; retired_count=0; wait counter=0.
  - reg_write, mem_read, mem_write, done, illegal, busy all 0.
  - instr_ready=0 while rst=0; it asserts in the first cycle after release.
  - Reset mid-instruction aborts it immediately: no strobe completes and no retire is counted.
- States (3-bit): IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4. No other codes are reachable; unused codes go to IDLE.
- IDLE:
  - instr_ready=1.
  - When instr_valid=1 at a rising edge: ir<=instr_word, next state DECODE. Otherwise stay in IDLE.
  - instr_word is ignored in all other states; instr_ready=0 outside IDLE.
- DECODE:
  - Legal means: opcode 0 with funct in {32,34,36,37,42}, or opcode 35, or opcode 43.
  - Illegal: illegal=1 for this cycle, next state IDLE, no strobes, no retire.
  - Legal: next state EXEC.
- EXEC: one cycle.
  - R-type: next state WB.
  - lw/sw: next state MEM; wait counter loads MEM_WAIT.
- MEM:
  - lw holds mem_read=1 for the whole phase; sw holds mem_write=1 for the whole phase.
  - Counter decrements each cycle and the phase exits when the counter is 0. Phase length is exactly MEM_WAIT+1 cycles.
  - On exit, lw goes to WB. sw goes to IDLE with done=1 in its last MEM cycle.
- WB: reg_write=1 and done=1 for exactly one cycle; next state IDLE.
- Static controls are combinational from ir and valid in DECODE through WB:
  - R-type: mem_to_reg=1, reg_dst=1, alu_src=0, alu_op=10.
  - lw: mem_to_reg=0, reg_dst=0, alu_src=1, alu_op=00.
  - sw: mem_to_reg=1, reg_dst=0, alu_src=1, alu_op=00.
  - Illegal or IDLE: all 0.
- Latency, counted from the accepting edge to the done cycle:
  - R-type: 3 cycles.
  - lw: 4+MEM_WAIT cycles.
  - sw: 3+MEM_WAIT cycles.
- Throughput: the next instruction is accepted at the edge that ends the cycle after done (one IDLE cycle minimum).
- retired_count increments at the edge ending each done cycle and wraps from 2^CNT_W-1 to 0.
- Strobes are outputs of registered state decode, with no glitches: each strobe is a clean high level for the stated cycles.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds output busy_cycles [31:0].
  - Increments on every rising edge where busy=1; saturates at 32'hFFFFFFFF.
  - Cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then add r3,r1,r2 (0x00221820) with MEM_WAIT=0 -> instr_ready drops the cycle after accept; reg_write pulses one cycle, 3 cycles after accept; reg_dst=1, alu_op=10; retired_count=1.
- lw (0x8C220004) with MEM_WAIT=2 -> mem_read high exactly 3 consecutive cycles, then reg_write one cycle; done 6 cycles after accept; mem_to_reg=0.
- sw (0xAC220008) with MEM_WAIT=0 -> mem_write high 1 cycle, with done in the same cycle; reg_write never asserts.
- Opcode 0x3F, then R-type funct 0x03 -> illegal pulses 1 cycle each, in the DECODE cycle; no strobes; retired_count unchanged; instr_ready returns 1 the next cycle.
- Assert rst=0 during the lw MEM phase -> mem_read, busy and ir go to 0 immediately; after release, state is IDLE and retired_count=0. Counter test with CNT_W=2: 5 back-to-back R-types give retired_count=1 (wrap).
- With SEQ_PERF_CNT_EN defined, one R-type plus one lw at MEM_WAIT=0 -> busy_cycles=7.
